// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART states and frame constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int BT_MIN      = 4;
    localparam int DATA_BITS_7 = 7;
    localparam int DATA_BITS_8 = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit period counter with one-cycle done pulse
module uart_bit_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] r_cnt;
    logic         w_last;

    assign w_last = (r_cnt == limit - W'(1));
    assign done   = enable && !load && w_last;

    // The counter rewinds on done so the next bit period starts without a gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_last ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - asynchronous serial frame receiver with error flags
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int BT_W = 20
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx_sync,
    input  logic [BT_W-1:0] bit_time,
    input  logic            eight,
    input  logic            pen,
    input  logic            ohel,
    input  logic            rd_ack,
    output logic [7:0]      rdata,
    output logic            rxrdy,
    output logic            perr,
    output logic            ferr,
    output logic            ovf
);

    uart_state_t     r_state;
    uart_state_t     w_next;
    logic [BT_W-1:0] r_bt;
    logic            r_eight;
    logic            r_pen;
    logic            r_ohel;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_pbad;
    logic [7:0]      r_rdata;
    logic            r_rxrdy;
    logic            r_perr;
    logic            r_ferr;
    logic            r_ovf;

    logic            w_start;
    logic            w_done;
    logic            w_last_bit;
    logic [BT_W-1:0] w_limit;
    logic [BT_W-1:0] w_bt_clamped;
    logic [7:0]      w_data;

    assign w_start      = (r_state == IDLE) && !rx_sync;
    assign w_limit      = (r_state == START) ? (r_bt >> 1) : r_bt;
    assign w_bt_clamped = (bit_time < BT_W'(BT_MIN)) ? BT_W'(BT_MIN) : bit_time;
    assign w_last_bit   = (r_bitcnt == (r_eight ? 3'(DATA_BITS_8 - 1) : 3'(DATA_BITS_7 - 1)));
    // Bits enter from the MSB side, so a 7-bit frame sits in [7:1].
    assign w_data       = r_eight ? r_shift : {1'b0, r_shift[7:1]};

    uart_bit_timer #(.W(BT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_start),
        .enable  (r_state != IDLE),
        .limit   (w_limit),
        .done    (w_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (!rx_sync) w_next = START;
            START:   if (w_done) w_next = rx_sync ? IDLE : DATA;
            DATA:    if (w_done && w_last_bit) w_next = r_pen ? PARITY : STOP;
            PARITY:  if (w_done) w_next = STOP;
            STOP:    if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bt     <= BT_W'(BT_MIN);
            r_eight  <= 1'b0;
            r_pen    <= 1'b0;
            r_ohel   <= 1'b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_pbad   <= 1'b0;
        end else begin
            if (w_start) begin
                r_bt    <= w_bt_clamped;
                r_eight <= eight;
                r_pen   <= pen;
                r_ohel  <= ohel;
                r_pbad  <= 1'b0;
            end
            if (r_state == START && w_done) begin
                r_bitcnt <= '0;
            end
            if (r_state == DATA && w_done) begin
                r_shift  <= {rx_sync, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (r_state == PARITY && w_done) begin
                r_pbad <= (rx_sync != (^w_data ^ r_ohel));
            end
        end
    end

    // A completing frame outranks a simultaneous acknowledge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == STOP && w_done) begin
            r_rdata <= w_data;
            r_rxrdy <= 1'b1;
            r_perr  <= r_pen & r_pbad;
            r_ferr  <= ~rx_sync;
            r_ovf   <= r_rxrdy & ~rd_ack;
        end else if (rd_ack && r_rxrdy) begin
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovf   <= 1'b0;
        end
    end

    assign rdata = r_rdata;
    assign rxrdy = r_rxrdy;
    assign perr  = r_perr;
    assign ferr  = r_ferr;
    assign ovf   = r_ovf;

endmodule
